// File: rtl/hwpe_stream_tcdm_req_slice.sv
// hwpe_stream_tcdm_req_slice
// Single-channel TCDM request/response slice. A 2-entry request buffer cuts
// the combinational grant path, and the number of granted-but-unanswered
// transactions is capped at MAX_OUTSTANDING. Responses come back in order.
// Optional macro HWPE_TCDM_SLICE_RSP_REG_EN registers the response path,
// adding one cycle of response latency.
module hwpe_stream_tcdm_req_slice #(
    parameter int unsigned ADDR_WIDTH      = 32,
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned BE_WIDTH        = DATA_WIDTH / 8,
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic                                     clk_i,
    input  logic                                     rst_i,
    input  logic                                     clear_i,
    input  logic                                     in_req,
    output logic                                     in_gnt,
    input  logic [ADDR_WIDTH-1:0]                    in_add,
    input  logic                                     in_wen,
    input  logic [BE_WIDTH-1:0]                      in_be,
    input  logic [DATA_WIDTH-1:0]                    in_data,
    output logic                                     in_r_valid,
    output logic [DATA_WIDTH-1:0]                    in_r_data,
    output logic                                     out_req,
    input  logic                                     out_gnt,
    output logic [ADDR_WIDTH-1:0]                    out_add,
    output logic                                     out_wen,
    output logic [BE_WIDTH-1:0]                      out_be,
    output logic [DATA_WIDTH-1:0]                    out_data,
    input  logic                                     out_r_valid,
    input  logic [DATA_WIDTH-1:0]                    out_r_data,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0]     outstanding_o,
    output logic                                     rsp_overflow_o
);

    localparam int unsigned CNT_WIDTH = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned REQ_WIDTH = ADDR_WIDTH + 1 + BE_WIDTH + DATA_WIDTH;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(MAX_OUTSTANDING);

    logic                 flush;
    logic                 push;
    logic                 pop;
    logic                 full;
    logic                 empty;
    logic                 deliver;
    logic                 stray;

    logic [REQ_WIDTH-1:0] buf_q [2];
    logic                 rd_ptr_q;
    logic                 wr_ptr_q;
    logic [1:0]           fill_q;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic                 overflow_q;

    assign flush = rst_i | clear_i;
    assign full  = (fill_q == 2'd2);
    assign empty = (fill_q == 2'd0);

    // Grant uses registered state only, so out_gnt never reaches in_gnt.
    assign in_gnt = !flush && !full && (cnt_q < CNT_MAX);
    assign push   = in_req & in_gnt;
    assign pop    = out_req & out_gnt;

    assign out_req = !empty;
    assign {out_add, out_wen, out_be, out_data} = buf_q[rd_ptr_q];

    // Request buffer storage; contents need no reset, fill level gates use.
    always_ff @(posedge clk_i) begin
        if (push) begin
            buf_q[wr_ptr_q] <= {in_add, in_wen, in_be, in_data};
        end
    end

    // Request buffer pointers and fill level.
    always_ff @(posedge clk_i) begin
        if (flush) begin
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            fill_q   <= 2'd0;
        end else begin
            if (push) wr_ptr_q <= ~wr_ptr_q;
            if (pop)  rd_ptr_q <= ~rd_ptr_q;
            case ({push, pop})
                2'b10:   fill_q <= fill_q + 2'd1;
                2'b01:   fill_q <= fill_q - 2'd1;
                default: fill_q <= fill_q;
            endcase
        end
    end

`ifdef HWPE_TCDM_SLICE_RSP_REG_EN
    logic                  rsp_valid_q;
    logic [DATA_WIDTH-1:0] rsp_data_q;
    logic                  rsp_accept;

    // cnt_q still includes a response sitting in the register, so a new
    // response is legitimate only if more than that one is outstanding.
    assign rsp_accept = out_r_valid && !flush && (cnt_q > CNT_WIDTH'(rsp_valid_q));
    assign stray      = out_r_valid && !flush && !rsp_accept;

    // Response register valid bit.
    always_ff @(posedge clk_i) begin
        if (flush) begin
            rsp_valid_q <= 1'b0;
        end else begin
            rsp_valid_q <= rsp_accept;
        end
    end

    // Response register data.
    always_ff @(posedge clk_i) begin
        if (rsp_accept) begin
            rsp_data_q <= out_r_data;
        end
    end

    assign deliver   = rsp_valid_q & !flush;
    assign in_r_data = rsp_data_q;
`else
    assign deliver   = out_r_valid && !flush && (cnt_q != '0);
    assign stray     = out_r_valid && !flush && (cnt_q == '0);
    assign in_r_data = out_r_data;
`endif

    assign in_r_valid = deliver;

    // Outstanding counter: up on acceptance, down on delivery, saturating.
    always_ff @(posedge clk_i) begin
        if (flush) begin
            cnt_q <= '0;
        end else if (push && !deliver && (cnt_q != CNT_MAX)) begin
            cnt_q <= cnt_q + CNT_WIDTH'(1);
        end else if (!push && deliver && (cnt_q != '0)) begin
            cnt_q <= cnt_q - CNT_WIDTH'(1);
        end
    end

    // Sticky flag for responses that arrive with nothing outstanding.
    always_ff @(posedge clk_i) begin
        if (flush) begin
            overflow_q <= 1'b0;
        end else if (stray) begin
            overflow_q <= 1'b1;
        end
    end

    assign outstanding_o  = cnt_q;
    assign rsp_overflow_o = overflow_q;

endmodule

// File: tb/tb_hwpe_stream_tcdm_req_slice.sv
// Testbench for hwpe_stream_tcdm_req_slice: directed vectors with a
// scoreboard of expected requests and responses checked by a monitor.
module tb_hwpe_stream_tcdm_req_slice;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned BW = 4;
    localparam int unsigned MO = 4;
    localparam int unsigned CW = $clog2(MO + 1);
`ifdef HWPE_TCDM_SLICE_RSP_REG_EN
    localparam int RSP_LAT = 1;
`else
    localparam int RSP_LAT = 0;
`endif

    logic          clk;
    logic          rst;
    logic          clear;
    logic          in_req;
    logic          in_gnt;
    logic [AW-1:0] in_add;
    logic          in_wen;
    logic [BW-1:0] in_be;
    logic [DW-1:0] in_data;
    logic          in_r_valid;
    logic [DW-1:0] in_r_data;
    logic          out_req;
    logic          out_gnt;
    logic [AW-1:0] out_add;
    logic          out_wen;
    logic [BW-1:0] out_be;
    logic [DW-1:0] out_data;
    logic          out_r_valid;
    logic [DW-1:0] out_r_data;
    logic [CW-1:0] outstanding;
    logic          overflow;

    logic          auto_rsp;
    logic          man_v;
    logic [DW-1:0] man_d;
    logic          mem_hs;
    logic [AW-1:0] mem_a;

    int tests = 0;
    int fails = 0;

    logic [DW-1:0]   rsp_q [$];
    logic [AW+DW:0]  req_q [$];

    hwpe_stream_tcdm_req_slice #(
        .ADDR_WIDTH      (AW),
        .DATA_WIDTH      (DW),
        .BE_WIDTH        (BW),
        .MAX_OUTSTANDING (MO)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .clear_i        (clear),
        .in_req         (in_req),
        .in_gnt         (in_gnt),
        .in_add         (in_add),
        .in_wen         (in_wen),
        .in_be          (in_be),
        .in_data        (in_data),
        .in_r_valid     (in_r_valid),
        .in_r_data      (in_r_data),
        .out_req        (out_req),
        .out_gnt        (out_gnt),
        .out_add        (out_add),
        .out_wen        (out_wen),
        .out_be         (out_be),
        .out_data       (out_data),
        .out_r_valid    (out_r_valid),
        .out_r_data     (out_r_data),
        .outstanding_o  (outstanding),
        .rsp_overflow_o (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DW-1:0] rdata(input logic [AW-1:0] a);
        return a ^ 32'hDEAD_0000;
    endfunction

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One request cycle; the expected grant is hand-computed by the caller.
    task automatic issue(input logic [AW-1:0] a, input logic wen, input logic exp_gnt);
        @(posedge clk); #1;
        in_req  = 1'b1;
        in_add  = a;
        in_wen  = wen;
        in_be   = '1;
        in_data = ~a;
        @(negedge clk);
        check("in_gnt", 96'(in_gnt), 96'(exp_gnt));
        if (exp_gnt) begin
            rsp_q.push_back(rdata(a));
            req_q.push_back({wen, a, ~a});
        end
    endtask

    task automatic idle();
        @(posedge clk); #1;
        in_req = 1'b0;
    endtask

    task automatic respond(input logic [DW-1:0] d);
        @(posedge clk); #1;
        man_v = 1'b1;
        man_d = d;
        @(posedge clk); #1;
        man_v = 1'b0;
        repeat (RSP_LAT) @(posedge clk);
        @(negedge clk);
    endtask

    // Memory model: answers each out handshake one cycle later, or
    // replays a manually requested response.
    initial begin
        out_r_valid = 1'b0;
        out_r_data  = '0;
        forever begin
            @(negedge clk);
            mem_hs = auto_rsp && out_req && out_gnt;
            mem_a  = out_add;
            @(posedge clk); #2;
            out_r_valid = mem_hs | man_v;
            out_r_data  = mem_hs ? rdata(mem_a) : man_d;
        end
    end

    // Monitor: compares every response and every issued request in order.
    initial begin
        logic [DW-1:0]  exp_d;
        logic [AW+DW:0] exp_r;
        forever begin
            @(negedge clk);
            if (in_r_valid) begin
                if (rsp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL rsp_unexpected: got in_r_valid=1 data %0h, required no response (t=%0t)", in_r_data, $time);
                end else begin
                    exp_d = rsp_q.pop_front();
                    check("rsp_data", 96'(in_r_data), 96'(exp_d));
                end
            end
            if (out_req && out_gnt) begin
                if (req_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL req_unexpected: got out_add %0h, required no request (t=%0t)", out_add, $time);
                end else begin
                    exp_r = req_q.pop_front();
                    check("out_req_fields", 96'({out_wen, out_add, out_data}), 96'(exp_r));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        rst      = 1'b1;
        clear    = 1'b0;
        in_req   = 1'b1;
        in_add   = 32'h0000_0F00;
        in_wen   = 1'b1;
        in_be    = '1;
        in_data  = '0;
        out_gnt  = 1'b0;
        auto_rsp = 1'b0;
        man_v    = 1'b0;
        man_d    = '0;

        // Reset held with a pending request.
        repeat (3) begin
            @(negedge clk);
            check("rst_in_gnt", 96'(in_gnt), 96'(0));
            check("rst_out_req", 96'(out_req), 96'(0));
            check("rst_count", 96'(outstanding), 96'(0));
        end
        check("rst_overflow", 96'(overflow), 96'(0));
        @(posedge clk); #1;
        rst    = 1'b0;
        in_req = 1'b0;
        @(negedge clk);
        check("post_rst_gnt", 96'(in_gnt), 96'(1));

        // Streaming reads with out_gnt held high.
        @(posedge clk); #1;
        out_gnt  = 1'b1;
        auto_rsp = 1'b1;
        for (int i = 0; i < 8; i++) issue(32'h100 + 32'(4 * i), 1'b1, 1'b1);
        idle();
        repeat (8) @(negedge clk);
        check("stream_count", 96'(outstanding), 96'(0));
        check("stream_rsp_left", 96'(rsp_q.size()), 96'(0));

        // Backpressure: two accepted, third refused while buffer full.
        @(posedge clk); #1;
        out_gnt = 1'b0;
        issue(32'h200, 1'b0, 1'b1);
        issue(32'h204, 1'b1, 1'b1);
        issue(32'h208, 1'b1, 1'b0);
        check("bp_out_req", 96'(out_req), 96'(1));
        check("bp_head_add", 96'(out_add), 96'(32'h200));
        check("bp_count", 96'(outstanding), 96'(2));
        @(posedge clk); #1;
        in_req  = 1'b0;
        out_gnt = 1'b1;
        repeat (8) @(negedge clk);
        check("bp_drained_count", 96'(outstanding), 96'(0));
        check("bp_req_left", 96'(req_q.size()), 96'(0));

        // Outstanding cap with no responses.
        @(posedge clk); #1;
        auto_rsp = 1'b0;
        for (int i = 0; i < 4; i++) issue(32'h300 + 32'(4 * i), 1'b1, 1'b1);
        issue(32'h310, 1'b1, 1'b0);
        issue(32'h310, 1'b1, 1'b0);
        idle();
        @(negedge clk);
        check("cap_count", 96'(outstanding), 96'(4));
        check("cap_gnt", 96'(in_gnt), 96'(0));
        respond(rdata(32'h300));
        check("cap_count_after_rsp", 96'(outstanding), 96'(3));
        check("cap_gnt_after_rsp", 96'(in_gnt), 96'(1));
        respond(rdata(32'h304));
        check("count_before_simul", 96'(outstanding), 96'(2));

        // Simultaneous acceptance and delivery at count 2.
        @(posedge clk); #1;
        man_v = 1'b1;
        man_d = rdata(32'h308);
        if (RSP_LAT != 0) begin
            @(posedge clk); #1;
            man_v = 1'b0;
        end
        in_req  = 1'b1;
        in_add  = 32'h320;
        in_wen  = 1'b1;
        in_data = ~32'h320;
        @(negedge clk);
        check("simul_gnt", 96'(in_gnt), 96'(1));
        rsp_q.push_back(rdata(32'h320));
        req_q.push_back({1'b1, 32'h320, ~32'h320});
        @(posedge clk); #1;
        in_req = 1'b0;
        man_v  = 1'b0;
        @(negedge clk);
        check("simul_count", 96'(outstanding), 96'(2));

        // Clear with two outstanding, then two late responses.
        @(posedge clk); #1;
        clear = 1'b1;
        @(negedge clk);
        check("clear_gnt", 96'(in_gnt), 96'(0));
        @(posedge clk); #1;
        clear = 1'b0;
        rsp_q.delete();
        req_q.delete();
        @(negedge clk);
        check("clear_count", 96'(outstanding), 96'(0));
        check("clear_overflow", 96'(overflow), 96'(0));
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            man_v = 1'b1;
            man_d = rdata(32'h30C + 32'(20 * i));
            @(negedge clk);
            check("stray_r_valid", 96'(in_r_valid), 96'(0));
        end
        @(posedge clk); #1;
        man_v = 1'b0;
        repeat (RSP_LAT) @(posedge clk);
        @(negedge clk);
        check("stray_overflow", 96'(overflow), 96'(1));
        check("stray_r_valid_late", 96'(in_r_valid), 96'(0));
        check("stray_count", 96'(outstanding), 96'(0));
        repeat (3) @(negedge clk);
        check("overflow_sticky", 96'(overflow), 96'(1));
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("overflow_cleared", 96'(overflow), 96'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/hwpe_stream_tcdm_req_slice.md
Name: hwpe_stream_tcdm_req_slice

Overview:
Single-channel TCDM request/response slice placed directly downstream of the static TCDM mux output, before the TCDM interconnect port.
- Breaks the combinational gnt path with a 2-entry request buffer.
- Caps outstanding transactions at MAX_OUTSTANDING and forwards in-order responses back to the mux.
- One instance per TCDM channel.

Parameters:
ADDR_WIDTH, 32, request address width
DATA_WIDTH, 32, write/read data width
BE_WIDTH, DATA_WIDTH/8, byte-enable width
MAX_OUTSTANDING, 4, max granted-but-unanswered transactions (>=1)

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous, active-high reset
clear_i  in  1  synchronous flush (same effect as rst_i)
in_req  in  1  slave request
in_gnt  out  1  slave grant
in_add  in  ADDR_WIDTH  slave address
in_wen  in  1  1=read, 0=write
in_be  in  BE_WIDTH  byte enables
in_data  in  DATA_WIDTH  write data
in_r_valid  out  1  response valid to slave
in_r_data  out  DATA_WIDTH  read data to slave
out_req  out  1  master request
out_gnt  in  1  master grant
out_add  out  ADDR_WIDTH  master address
out_wen  out  1  master wen
out_be  out  BE_WIDTH  master byte enables
out_data  out  DATA_WIDTH  master write data
out_r_valid  in  1  response valid from TCDM
out_r_data  in  DATA_WIDTH  read data from TCDM
outstanding_o  out  $clog2(MAX_OUTSTANDING+1)  current outstanding count
rsp_overflow_o  out  1  sticky: response received with count 0

Behaviour:
- Clock and reset: clk_i, rst_i; reset is synchronous, active-high. clear_i behaves identically to rst_i.
- Reset/clear values: buffer empty, count 0, out_req=0, in_r_valid=0, rsp_overflow_o=0. in_gnt=0 in any cycle where rst_i or clear_i is high.
- Request buffer: 2-entry FIFO holding {add,wen,be,data}.
  - Push: in_req & in_gnt.
  - Pop: out_req & out_gnt.
  - out_req = !empty; out_* driven from the head entry. Head is stable while out_req & !out_gnt.
  - Minimum request latency: 1 cycle (accept in cycle N, out_req in N+1).
- Grant: in_gnt = !full & (count < MAX_OUTSTANDING).
  - Depends only on registered state; no combinational path from out_gnt to in_gnt.
  - Push and pop in the same cycle on a full buffer is not allowed, because in_gnt is already 0.
  - Sustained throughput: 1 request/cycle when out_gnt is held high.
- Outstanding count:
  - +1 on slave acceptance (in_req & in_gnt).
  - -1 on a delivered response (in_r_valid).
  - Both in the same cycle: unchanged.
  - Saturates at MAX_OUTSTANDING, never wraps.
  - Every granted request (read or write) produces exactly one out_r_valid, in order.
- Response path (default): in_r_valid = out_r_valid & (count != 0); in_r_data = out_r_data, combinational.
- Stray response (out_r_valid while count==0): dropped, not forwarded, and rsp_overflow_o sets. It stays set until rst_i/clear_i.
- clear_i mid-operation: buffered requests are discarded and never issued; responses arriving afterwards fall under the stray-response rule.
- Requests must hold stable while in_req & !in_gnt; the slice does not check this.

Optional Feature:
Macro HWPE_TCDM_SLICE_RSP_REG_EN.
- Defined:
  - out_r_valid/out_r_data are registered once before reaching in_r_valid/in_r_data, adding 1 cycle of response latency.
  - The count decrements when the registered response is delivered.
  - The stray-response check is applied at register input, against the count plus the pending registered response.
  - Reset/clear clears the register valid bit.
- Undefined: combinational response path as above.

Test Plan:
- Reset: hold rst_i 3 cycles with in_req=1 -> in_gnt=0, out_req=0, outstanding_o=0. First cycle after release -> in_gnt=1.
- Streaming: out_gnt=1, 8 back-to-back reads to 0x100..0x11C, response 1 cycle after out_gnt. Required:
  - in_gnt high every cycle.
  - out_add follows 1 cycle behind.
  - in_r_data is returned in the same order.
- Backpressure: out_gnt=0, 3 requests -> 2 accepted, then in_gnt=0 (full). out_add holds the first address. Releasing out_gnt drains in order.
- Outstanding cap: MAX_OUTSTANDING=4, out_gnt=1, no responses, 6 requests -> exactly 4 granted, outstanding_o=4, in_gnt=0. One response -> count 3, in_gnt=1.
- Simultaneous accept and response at count 2 -> count stays 2.
- Stray response: clear_i asserted with 2 outstanding, then out_r_valid twice -> in_r_valid stays 0, rsp_overflow_o=1 until next rst_i. Repeat with HWPE_TCDM_SLICE_RSP_REG_EN -> response latency +1 cycle.
